// File: rtl/key_event_arbiter.sv
// Key event arbiter: merges one-cycle press pulses from several debounced key channels into a
// single event FIFO using round-robin arbitration. Exposes the head key index, occupancy,
// a sticky lost-press flag and a level interrupt.
module key_event_arbiter #(
  parameter int unsigned NUM_KEYS   = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned IDX_W     = $clog2(NUM_KEYS),
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [NUM_KEYS-1:0] key_pulse,
  input  logic                irq_en,
  input  logic                ovf_clr,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [IDX_W-1:0]    evt_code,
  output logic [CNT_W-1:0]    evt_count,
  output logic                ovf,
  output logic                irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] r_pend;
  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;

  logic [NUM_KEYS-1:0] w_req;
  logic [NUM_KEYS-1:0] w_grant;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_push;
  logic                w_pop;
  logic                w_can_push;
  logic                w_loss;
  logic                w_not_empty;

  // A pulse requests in the same cycle it arrives; pend holds requests not yet granted.
  assign w_req       = r_pend | key_pulse;
  assign w_not_empty = (r_count != '0);
  // Full blocks push even if a pop happens this cycle.
  assign w_can_push  = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_pop       = w_not_empty & evt_ready;
  assign w_push      = |w_grant;
  // A second press on a key whose earlier press is still waiting collapses into one event.
  assign w_loss      = |(r_pend & key_pulse & ~w_grant);

  // Round-robin search starting one past the last granted index, wrapping at NUM_KEYS-1.
  always_comb begin : p_arb
    int unsigned v_idx;
    logic        v_found;
    w_grant     = '0;
    w_grant_idx = '0;
    v_found     = 1'b0;
    v_idx       = 0;
    for (int unsigned k = 1; k <= NUM_KEYS; k++) begin
      v_idx = (32'(r_last_grant) + k) % NUM_KEYS;
      if (w_can_push && !v_found && w_req[v_idx]) begin
        v_found          = 1'b1;
        w_grant[v_idx]   = 1'b1;
        w_grant_idx      = IDX_W'(v_idx);
      end
    end
  end

  // Control state: pending requests, arbitration pointer, FIFO pointers/count, overflow flag.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_pend       <= '0;
      r_last_grant <= IDX_W'(NUM_KEYS - 1);
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_pend <= (w_req & ~w_grant) | (r_pend & key_pulse);
      if (w_push) begin
        r_last_grant <= w_grant_idx;
        r_wr_ptr     <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_loss) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Event storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_grant_idx;
    end
  end

  assign evt_valid = w_not_empty;
  // Code forced to zero when empty so stale storage never shows on the bus.
  assign evt_code  = w_not_empty ? r_mem[r_rd_ptr] : '0;
  assign evt_count = r_count;
  assign ovf       = r_ovf;
  assign irq       = irq_en & w_not_empty;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter with hand-computed expected values.
module tb_key_event_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] key_pulse;
  logic       irq_en;
  logic       ovf_clr;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [3:0] evt_count;
  logic       ovf;
  logic       irq;

  int vectors = 0;
  int miscompares = 0;

  key_event_arbiter #(
    .NUM_KEYS  (4),
    .FIFO_DEPTH(8)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .key_pulse(key_pulse),
    .irq_en   (irq_en),
    .ovf_clr  (ovf_clr),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .evt_count(evt_count),
    .ovf      (ovf),
    .irq      (irq)
  );

  always #5 HCLK = ~HCLK;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    key_pulse = '0;
    ovf_clr = 1'b0;
    evt_ready = 1'b0;
    step();
    step();
    HRESETn = 1'b1;
  endtask

  task automatic pulse(input logic [3:0] k);
    key_pulse = k;
    step();
    key_pulse = '0;
  endtask

  initial begin
    irq_en = 1'b1;
    do_reset();

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      chk("idle_valid", evt_valid, 0);
      chk("idle_count", evt_count, 0);
      chk("idle_code", evt_code, 0);
      chk("idle_irq", irq, 0);
      chk("idle_ovf", ovf, 0);
      step();
    end

    // Single press, irq masked then enabled
    irq_en = 1'b0;
    pulse(4'b0100);
    chk("single_valid", evt_valid, 1);
    chk("single_code", evt_code, 2);
    chk("single_count", evt_count, 1);
    chk("single_irq_masked", irq, 0);
    irq_en = 1'b1;
    #1;
    chk("single_irq_en", irq, 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("single_pop_valid", evt_valid, 0);
    chk("single_pop_count", evt_count, 0);
    chk("single_pop_irq", irq, 0);
    // Pop while empty is ignored
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("empty_pop_count", evt_count, 0);

    // All four keys at once from reset
    do_reset();
    pulse(4'b1111);
    chk("all_cnt1", evt_count, 1);
    chk("all_head", evt_code, 0);
    step();
    chk("all_cnt2", evt_count, 2);
    step();
    chk("all_cnt3", evt_count, 3);
    step();
    chk("all_cnt4", evt_count, 4);
    chk("all_ovf", ovf, 0);
    step();
    chk("all_cnt_hold", evt_count, 4);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("all_code", evt_code, i);
      step();
    end
    evt_ready = 1'b0;
    chk("all_drained", evt_count, 0);

    // Round-robin with last grant = 1: order 0 then 1
    pulse(4'b0010);
    chk("rr1_prep_code", evt_code, 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    pulse(4'b0011);
    step();
    chk("rr1_count", evt_count, 2);
    chk("rr1_first", evt_code, 0);
    evt_ready = 1'b1;
    step();
    chk("rr1_second", evt_code, 1);
    step();
    evt_ready = 1'b0;
    chk("rr1_empty", evt_count, 0);

    // Round-robin with last grant = 0: order 1 then 0
    pulse(4'b0001);
    chk("rr0_prep_code", evt_code, 0);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    pulse(4'b0011);
    step();
    chk("rr0_count", evt_count, 2);
    chk("rr0_first", evt_code, 1);
    evt_ready = 1'b1;
    step();
    chk("rr0_second", evt_code, 0);
    step();
    evt_ready = 1'b0;
    chk("rr0_empty", evt_count, 0);

    // Full FIFO behaviour
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pulse(4'b0001 << (i % 3));
    end
    chk("full_count", evt_count, 8);
    chk("full_head", evt_code, 0);
    pulse(4'b1000);
    step();
    chk("full_blocked", evt_count, 8);
    chk("full_no_ovf", ovf, 0);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("full_after_pop", evt_count, 7);
    chk("full_next_head", evt_code, 1);
    step();
    chk("full_pend_pushed", evt_count, 8);
    pulse(4'b1000);
    chk("full_pend_ovf0", ovf, 0);
    pulse(4'b1000);
    chk("full_loss_ovf", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    pulse(4'b1000);
    chk("ovf_reset_again", ovf, 1);
    ovf_clr = 1'b1;
    pulse(4'b1000);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr_final", ovf, 0);

    // Mid-operation reset with count=5, pend=4'b1010
    do_reset();
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b1110);
    chk("mid_count5", evt_count, 5);
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    chk("mid_rst_count", evt_count, 0);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_ovf", ovf, 0);
    step();
    step();
    chk("mid_no_stale_count", evt_count, 0);
    chk("mid_no_stale_valid", evt_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
